// File: rtl/line_edit_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_edit_buf_if
//  Description : Key-event handshake bundle between the key classifier
//                (master) and the line edit buffer (slave).
//                  key_valid  - event present this cycle
//                  key_ready  - slave can accept; transfer on valid & ready
//                  key_code   - 0 NOP, 1 CHAR, 2 LEFT, 3 RIGHT, 4 DEL,
//                               5 BKSP, 6 ENTER, 7 reserved
//                  key_char   - byte to insert, meaningful with CHAR only
//  Revision    : 1.0  initial release
// ============================================================================
interface line_edit_buf_if;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] key_code;
  logic [7:0] key_char;

  modport master (output key_valid, output key_code, output key_char,
                  input  key_ready);
  modport slave  (input  key_valid, input  key_code, input  key_char,
                  output key_ready);
endinterface
`default_nettype wire

// File: rtl/line_edit_buf.sv
`default_nettype none
// ============================================================================
//  Module      : line_edit_buf
//  Description : Editable line buffer with cursor. Accepts decoded key
//                events, shifts the tail one byte per clock on mid-line
//                insert/delete, and publishes a finished line on ENTER.
//  Ports       : clk, reset (async, active-high)
//                key        - key-event handshake (slave modport)
//                cursor     - insert position, 0..length
//                length     - valid bytes, 0..DEPTH
//                rd_addr    - buffer read address
//                rd_data    - combinational buf[rd_addr]
//                line_done  - one-cycle pulse when ENTER is accepted
//                line_len   - length of last completed line (held)
//                ovf        - one-cycle pulse when a CHAR is dropped (full)
//  Revision    : 1.0  initial release
// ============================================================================
module line_edit_buf #(
  parameter  int DEPTH = 32,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  wire            clk,
  input  wire            reset,
  line_edit_buf_if.slave key,
  output logic [LW-1:0]  cursor,
  output logic [LW-1:0]  length,
  input  wire  [LW-1:0]  rd_addr,
  output logic [7:0]     rd_data,
  output logic           line_done,
  output logic [LW-1:0]  line_len,
  output logic           ovf
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [LW-1:0] ONE  = LW'(1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Codes 0 (NOP) and 7 (reserved) fall through to "no effect".
  localparam logic [2:0] K_CHAR  = 3'd1;
  localparam logic [2:0] K_LEFT  = 3'd2;
  localparam logic [2:0] K_RIGHT = 3'd3;
  localparam logic [2:0] K_DEL   = 3'd4;
  localparam logic [2:0] K_BKSP  = 3'd5;
  localparam logic [2:0] K_ENTER = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_R = 2'd1,
    SHIFT_L = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [LW-1:0] cursor_n, length_n, line_len_n;
  logic [LW-1:0] idx, idx_n;      // current shift target position
  logic [7:0]    ch, ch_n;        // latched character for insert
  logic          ins, ins_n;      // COMMIT flavour: 1 insert, 0 delete
  logic          line_done_n, ovf_n;

  logic [7:0]    mem [0:DEPTH-1];
  logic          we;
  logic [LW-1:0] waddr;
  logic [7:0]    wdata;

  logic [LW-1:0] idx_m1, idx_p1;
  logic [7:0]    mem_m1, mem_p1;

  assign idx_m1 = idx - ONE;
  assign idx_p1 = idx + ONE;
  assign mem_m1 = mem[idx_m1[AW-1:0]];
  assign mem_p1 = mem[idx_p1[AW-1:0]];
  assign rd_data = mem[rd_addr[AW-1:0]];

  assign key.key_ready = (state == IDLE);

  // Address bits above the storage index width are never needed to
  // select a byte; fold them into a sink so they are visibly consumed.
  generate
    if (LW > AW) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{idx_m1[LW-1:AW], idx_p1[LW-1:AW], rd_addr[LW-1:AW]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    cursor_n    = cursor;
    length_n    = length;
    line_len_n  = line_len;
    idx_n       = idx;
    ch_n        = ch;
    ins_n       = ins;
    line_done_n = 1'b0;
    ovf_n       = 1'b0;
    we          = 1'b0;
    waddr       = idx;
    wdata       = ch;

    case (state)
      IDLE: begin
        if (key.key_valid) begin
          case (key.key_code)
            K_LEFT: begin
              if (cursor != '0) cursor_n = cursor - ONE;
            end
            K_RIGHT: begin
              if (cursor != length) cursor_n = cursor + ONE;
            end
            K_ENTER: begin
              line_done_n = 1'b1;
              line_len_n  = length;
              length_n    = '0;
              cursor_n    = '0;
            end
            K_CHAR: begin
              if (length == FULL) begin
                ovf_n = 1'b1;
              end else begin
                ch_n    = key.key_char;
                ins_n   = 1'b1;
                idx_n   = length;   // first shift writes buf[length]
                state_n = (length != cursor) ? SHIFT_R : COMMIT;
              end
            end
            K_DEL: begin
              if (cursor != length) begin
                ins_n   = 1'b0;
                idx_n   = cursor;
                // Tail exists only if more than one byte follows the cursor.
                state_n = (cursor + ONE != length) ? SHIFT_L : COMMIT;
              end
            end
            K_BKSP: begin
              if (cursor != '0) begin
                cursor_n = cursor - ONE;
                ins_n    = 1'b0;
                idx_n    = cursor - ONE;
                // Delete at cursor-1: shift count is length - cursor.
                state_n  = (cursor != length) ? SHIFT_L : COMMIT;
              end
            end
            default: ;
          endcase
        end
      end

      SHIFT_R: begin
        we    = 1'b1;
        waddr = idx;
        wdata = mem_m1;
        if (idx == cursor + ONE) state_n = COMMIT;
        else                     idx_n   = idx_m1;
      end

      SHIFT_L: begin
        we    = 1'b1;
        waddr = idx;
        wdata = mem_p1;
        // Last move is into position length-2.
        if (idx_p1 + ONE == length) state_n = COMMIT;
        else                        idx_n   = idx_p1;
      end

      COMMIT: begin
        state_n = IDLE;
        if (ins) begin
          we       = 1'b1;
          waddr    = cursor;
          wdata    = ch;
          cursor_n = cursor + ONE;
          length_n = length + ONE;
        end else begin
          length_n = length - ONE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cursor    <= '0;
      length    <= '0;
      line_len  <= '0;
      idx       <= '0;
      ch        <= '0;
      ins       <= 1'b0;
      line_done <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      cursor    <= cursor_n;
      length    <= length_n;
      line_len  <= line_len_n;
      idx       <= idx_n;
      ch        <= ch_n;
      ins       <= ins_n;
      line_done <= line_done_n;
      ovf       <= ovf_n;
    end
  end

  // Storage is deliberately not reset; a write coinciding with reset is
  // dropped so an interrupted shift leaves no partial commit behind.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_line_edit_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_edit_buf
//  Description : Directed self-checking bench for line_edit_buf.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_edit_buf;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  localparam logic [2:0] K_NOP   = 3'd0;
  localparam logic [2:0] K_CHAR  = 3'd1;
  localparam logic [2:0] K_LEFT  = 3'd2;
  localparam logic [2:0] K_RIGHT = 3'd3;
  localparam logic [2:0] K_DEL   = 3'd4;
  localparam logic [2:0] K_BKSP  = 3'd5;
  localparam logic [2:0] K_ENTER = 3'd6;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] rd_addr;
  logic [LW-1:0] cursor, length, line_len;
  logic [7:0]    rd_data;
  logic          line_done, ovf;

  int n_asserts = 0;
  int n_fail    = 0;

  line_edit_buf_if kif ();

  line_edit_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (kif),
    .cursor    (cursor),
    .length    (length),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .line_done (line_done),
    .line_len  (line_len),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one event and return 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] code, input logic [7:0] ch);
    int guard;
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = code;
    kif.key_char  = ch;
    guard = 0;
    while (!kif.key_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!kif.key_ready) chk("send_ready_timeout", {31'd0, kif.key_ready}, 32'd1);
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
    kif.key_code  = K_NOP;
  endtask

  // Count cycles with key_ready low after an accept.
  task automatic wait_idle(output int busy);
    busy = 0;
    while (!kif.key_ready && busy < 200) begin
      @(posedge clk);
      #1;
      busy++;
    end
    if (!kif.key_ready) chk("idle_timeout", {31'd0, kif.key_ready}, 32'd1);
  endtask

  task automatic op(input logic [2:0] code, input logic [7:0] ch,
                    input int exp_busy, input string tag);
    int b;
    send(code, ch);
    wait_idle(b);
    chk(tag, b, exp_busy);
  endtask

  task automatic rd(input int addr, input logic [7:0] exp, input string tag);
    rd_addr = LW'(addr);
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_code  = K_NOP;
    kif.key_char  = 8'h00;
    rd_addr       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_ready",     {31'd0, kif.key_ready}, 32'd1);
    chk("rst_cursor",    cursor, 32'd0);
    chk("rst_length",    length, 32'd0);
    chk("rst_line_len",  line_len, 32'd0);
    chk("rst_line_done", {31'd0, line_done}, 32'd0);
    chk("rst_ovf",       {31'd0, ovf}, 32'd0);

    // Append "abc": one busy cycle each
    op(K_CHAR, 8'h61, 1, "busy_a");
    op(K_CHAR, 8'h62, 1, "busy_b");
    op(K_CHAR, 8'h63, 1, "busy_c");
    chk("abc_length", length, 32'd3);
    chk("abc_cursor", cursor, 32'd3);
    rd(0, 8'h61, "abc_rd0");
    rd(1, 8'h62, "abc_rd1");
    rd(2, 8'h63, "abc_rd2");

    // LEFT x2, insert 'X' mid-line -> "aXbc"
    op(K_LEFT, 8'h00, 0, "busy_left1");
    op(K_LEFT, 8'h00, 0, "busy_left2");
    chk("left2_cursor", cursor, 32'd1);
    op(K_CHAR, 8'h58, 3, "busy_insX");
    chk("insX_cursor", cursor, 32'd2);
    chk("insX_length", length, 32'd4);
    rd(0, 8'h61, "insX_rd0");
    rd(1, 8'h58, "insX_rd1");
    rd(2, 8'h62, "insX_rd2");
    rd(3, 8'h63, "insX_rd3");

    // BKSP -> "abc", cursor 1
    op(K_BKSP, 8'h00, 3, "busy_bksp");
    chk("bksp_cursor", cursor, 32'd1);
    chk("bksp_length", length, 32'd3);
    rd(1, 8'h62, "bksp_rd1");
    rd(2, 8'h63, "bksp_rd2");

    // DEL -> "ac"
    op(K_DEL, 8'h00, 2, "busy_del");
    chk("del_cursor", cursor, 32'd1);
    chk("del_length", length, 32'd2);
    rd(0, 8'h61, "del_rd0");
    rd(1, 8'h63, "del_rd1");

    // LEFT x3 saturates, BKSP at 0 is a no-op
    op(K_LEFT, 8'h00, 0, "busy_l3a");
    op(K_LEFT, 8'h00, 0, "busy_l3b");
    op(K_LEFT, 8'h00, 0, "busy_l3c");
    chk("sat_cursor", cursor, 32'd0);
    op(K_BKSP, 8'h00, 0, "busy_bksp0");
    chk("bksp0_cursor", cursor, 32'd0);
    chk("bksp0_length", length, 32'd2);
    rd(0, 8'h61, "bksp0_rd0");

    // ENTER on "ac"
    send(K_ENTER, 8'h00);
    chk("enter_done",     {31'd0, line_done}, 32'd1);
    chk("enter_line_len", line_len, 32'd2);
    chk("enter_length",   length, 32'd0);
    chk("enter_cursor",   cursor, 32'd0);
    chk("enter_ovf",      {31'd0, ovf}, 32'd0);
    chk("enter_ready",    {31'd0, kif.key_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("enter_done_drop", {31'd0, line_done}, 32'd0);
    chk("enter_len_hold",  line_len, 32'd2);

    // Fill to capacity, then overflow
    for (int i = 0; i < DEPTH; i++) op(K_CHAR, 8'(8'h20 + i), 1, "busy_fill");
    chk("full_length", length, 32'(DEPTH));
    chk("full_cursor", cursor, 32'(DEPTH));
    send(K_CHAR, 8'h5A);
    chk("ovf_pulse",  {31'd0, ovf}, 32'd1);
    chk("ovf_ready",  {31'd0, kif.key_ready}, 32'd1);
    chk("ovf_length", length, 32'(DEPTH));
    chk("ovf_done",   {31'd0, line_done}, 32'd0);
    @(posedge clk);
    #1;
    chk("ovf_drop", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < DEPTH; i++) rd(i, 8'(8'h20 + i), "full_rd");
    op(K_RIGHT, 8'h00, 0, "busy_right_end");
    chk("right_end_cursor", cursor, 32'(DEPTH));
    op(K_DEL, 8'h00, 0, "busy_del_end");
    chk("del_end_length", length, 32'(DEPTH));
    send(K_ENTER, 8'h00);
    chk("enter_full_len", line_len, 32'(DEPTH));

    // Reset in the middle of SHIFT_R on a 20-byte line
    for (int i = 0; i < 20; i++) op(K_CHAR, 8'(8'h40 + i), 1, "busy_l20");
    for (int i = 0; i < 10; i++) op(K_LEFT, 8'h00, 0, "busy_l20_left");
    chk("l20_cursor", cursor, 32'd10);
    send(K_CHAR, 8'h4D);
    chk("shift_busy", {31'd0, kif.key_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("shift_busy2", {31'd0, kif.key_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready",  {31'd0, kif.key_ready}, 32'd1);
    chk("mid_rst_length", length, 32'd0);
    chk("mid_rst_cursor", cursor, 32'd0);
    chk("mid_rst_linelen", line_len, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_done", {31'd0, line_done}, 32'd0);
    chk("mid_rst_ovf",  {31'd0, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, kif.key_ready}, 32'd1);
    chk("post_rst_length", length, 32'd0);

    // Normal operation resumes
    op(K_CHAR, 8'h55, 1, "busy_resume");
    chk("resume_length", length, 32'd1);
    chk("resume_cursor", cursor, 32'd1);
    rd(0, 8'h55, "resume_rd0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_edit_buf.md
Name: line_edit_buf

Overview:
- Downstream consumer of the escape-sequence detector and key classifier in the terminal input path.
- Takes one decoded key event at a time (printable char, cursor left/right, Delete, BackSpace, Enter).
- Maintains an editable line buffer with a cursor. Inserting or deleting in the middle of the line shifts the tail one byte per clock.
- On Enter, publishes the completed line to the command parser through a read port and a done pulse.

Parameters:
- DEPTH, 32: line buffer capacity in bytes. Must be ≥ 2.
- LW, $clog2(DEPTH+1): width of the cursor and length fields. This is a localparam derived from DEPTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_valid  input  1  key event present this cycle.
- key_ready  output  1  block can accept an event; a transfer occurs when key_valid & key_ready at the clock edge.
- key_code  input  3  event code: 0 NOP, 1 CHAR, 2 LEFT, 3 RIGHT, 4 DEL, 5 BKSP, 6 ENTER, 7 reserved.
- key_char  input  8  byte to insert; sampled only with CHAR.
- cursor  output  LW  insert position, range 0..length.
- length  output  LW  number of valid bytes, range 0..DEPTH.
- rd_addr  input  LW  buffer read address.
- rd_data  output  8  combinational read of buf[rd_addr]; defined only for rd_addr < length.
- line_done  output  1  one-cycle pulse when ENTER is accepted.
- line_len  output  LW  length of the completed line; held from each line_done pulse until the next one.
- ovf  output  1  one-cycle pulse when a CHAR is dropped because the buffer is full.

Behaviour:
- Reset:
  - State = IDLE; cursor = 0, length = 0, line_len = 0.
  - line_done = 0, ovf = 0, key_ready = 1.
  - Buffer storage is not reset.
- FSM states: IDLE, SHIFT_R, SHIFT_L, COMMIT. key_ready = 1 only in IDLE.
- Single-edge ops, accepted in IDLE; key_ready stays 1:
  - NOP, code 7: no effect.
  - LEFT: cursor -= 1 if cursor > 0, else no change.
  - RIGHT: cursor += 1 if cursor < length, else no change.
  - ENTER: line_done = 1 and line_len = length in the next cycle; length and cursor cleared at the same edge.
  - CHAR with length == DEPTH: dropped; ovf = 1 for one cycle; buffer, cursor and length unchanged.
  - DEL with cursor == length: no effect.
  - BKSP with cursor == 0: no effect.
- CHAR (length < DEPTH):
  - Accept edge latches key_char and sets shift count n = length − cursor.
  - If n > 0, go to SHIFT_R. Each cycle performs buf[i] = buf[i−1], with i running from length down to cursor+1. There are n such cycles.
  - Then COMMIT: buf[cursor] = char, cursor += 1, length += 1.
  - key_ready is low for n+1 cycles after acceptance.
- DEL (cursor < length):
  - n = length − cursor − 1.
  - SHIFT_L cycles perform buf[i] = buf[i+1], with i running from cursor to length−2.
  - COMMIT: length −= 1; cursor unchanged.
  - key_ready is low for n+1 cycles.
- BKSP (cursor > 0):
  - cursor −= 1 at the accept edge.
  - Then proceeds exactly as DEL at the new cursor.
- Events presented while key_ready = 0 are not consumed; the upstream stage holds key_valid and key_code stable until accepted.
- line_done and ovf never assert in the same cycle, since they come from different accepted events.
- Reset asserted mid-shift:
  - Returns immediately to IDLE with cursor = length = 0.
  - The partial shift is discarded; no line_done.

Test Plan:
- Reset, then CHAR 'a','b','c' (0x61,0x62,0x63) appended → length=3, cursor=3; rd_data at addr 0..2 = 61,62,63; key_ready low exactly 1 cycle per CHAR.
- From "abc", LEFT ×2 then CHAR 'X' → buffer "aXbc", cursor=2, length=4; key_ready low 3 cycles (2 shifts + commit).
- From "aXbc" with cursor=2, BKSP → "abc", cursor=1. Then DEL → "ac", cursor=1, length=2. Then LEFT ×3 → cursor=0 (saturates). Then BKSP → no change.
- Fill DEPTH=32 bytes, then CHAR → ovf pulses 1 cycle; length stays 32; contents unchanged. RIGHT at cursor=32 → no change.
- "ac" + ENTER → line_done=1 for one cycle, line_len=2; next cycle length=0, cursor=0; line_len holds 2.
- Assert reset during SHIFT_R of an insert into a 20-byte line → next cycle key_ready=1, length=0, cursor=0, no line_done or ovf.
